// File: rtl/ppu_regfile.sv
// PPU CPU-facing register file: PPUCTRL/MASK/STATUS, OAM port,
// scroll/address latches and the PPUDATA VRAM request FSM.
module ppu_regfile #(
    parameter int ADDR_W = 14,
    parameter int OAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_strobe,
    input  logic              cpu_rnw,
    input  logic [2:0]        cpu_a,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              vblank_set,
    input  logic              vblank_clr,
    input  logic              sprite0_hit,
    input  logic              sprite_ovf,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic [OAM_AW-1:0] oam_addr,
    output logic              oam_we,
    output logic [7:0]        oam_wdata,
    input  logic [7:0]        oam_rdata,
    output logic [7:0]        ppuctrl,
    output logic [7:0]        ppumask,
    output logic [14:0]       v,
    output logic [14:0]       t,
    output logic [2:0]        fine_x,
    output logic              n_vbl,
    output logic              overrun
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic        w;
    logic        vblank;
    logic [7:0]  rd_buf;
    logic        wr, rd, data_acc, issue;
    logic [14:0] inc;

    assign wr       = cpu_strobe & ~cpu_rnw;
    assign rd       = cpu_strobe & cpu_rnw;
    assign data_acc = cpu_strobe & (cpu_a == 3'd7);
    assign issue    = data_acc & (state == IDLE);
    assign inc      = ppuctrl[2] ? 15'd32 : 15'd1;

    assign oam_wdata = cpu_wdata;
    assign n_vbl     = ~(vblank & ppuctrl[7]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        vram_req = 1'b0;
        overrun  = 1'b0;
        oam_we   = wr & (cpu_a == 3'd4);
        unique case (state)
            IDLE: begin
                if (issue) state_nx = WAIT;
            end
            WAIT: begin
                vram_req = 1'b1;
                overrun  = data_acc;
                if (vram_ack) state_nx = IDLE;
            end
            default: ;
        endcase
        if (reset) begin
            vram_req = 1'b0;
            overrun  = 1'b0;
            oam_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ppuctrl    <= '0;
            ppumask    <= '0;
            v          <= '0;
            t          <= '0;
            fine_x     <= '0;
            w          <= 1'b0;
            vblank     <= 1'b0;
            rd_buf     <= '0;
            cpu_rdata  <= '0;
            oam_addr   <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            if (wr) begin
                unique case (cpu_a)
                    3'd0: begin
                        ppuctrl   <= cpu_wdata;
                        t[11:10]  <= cpu_wdata[1:0];
                    end
                    3'd1: ppumask <= cpu_wdata;
                    3'd3: oam_addr <= OAM_AW'(cpu_wdata);
                    3'd4: oam_addr <= oam_addr + OAM_AW'(1);
                    3'd5: begin
                        if (!w) begin
                            fine_x <= cpu_wdata[2:0];
                            t[4:0] <= cpu_wdata[7:3];
                        end else begin
                            t[14:12] <= cpu_wdata[2:0];
                            t[9:5]   <= cpu_wdata[7:3];
                        end
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[14:8] <= {1'b0, cpu_wdata[5:0]};
                        end else begin
                            t <= {t[14:8], cpu_wdata};
                            v <= {t[14:8], cpu_wdata};
                        end
                        w <= ~w;
                    end
                    default: ;
                endcase
            end
            // Write-only addresses leave cpu_rdata alone (open bus)
            if (rd) begin
                unique case (cpu_a)
                    3'd2: begin
                        cpu_rdata <= {vblank & ~vblank_set, sprite0_hit,
                                      sprite_ovf, 5'b0};
                        w <= 1'b0;
                    end
                    3'd4: cpu_rdata <= oam_rdata;
                    3'd7: if (state == IDLE) cpu_rdata <= rd_buf;
                    default: ;
                endcase
            end
            if (issue) begin
                v          <= v + inc;
                vram_we    <= ~cpu_rnw;
                vram_addr  <= v[ADDR_W-1:0];
                vram_wdata <= cpu_wdata;
            end
            if (state == WAIT && vram_ack && !vram_we)
                rd_buf <= vram_rdata;
            // Status read beats a coincident set, so the flag is suppressed
            if (rd && cpu_a == 3'd2) vblank <= 1'b0;
            else if (vblank_clr)     vblank <= 1'b0;
            else if (vblank_set)     vblank <= 1'b1;
        end
    end

endmodule
